// File: rtl/game_pkg.sv
// Shared game-state encoding and score constants for the score path and the scoreboard renderer.
package game_pkg;

    localparam int unsigned SCORE_W   = 10;
    localparam int unsigned SCORE_MAX = 999;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } game_state_t;

endpackage

// File: rtl/sat_counter.sv
// W-bit saturating up-counter with synchronous clear; holds at MAX instead of wrapping.
module sat_counter #(
    parameter int unsigned W   = 10,
    parameter int unsigned MAX = 999
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Clear has priority over increment; increments at MAX are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count < W'(MAX))) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Game-state tracker and saturating score producer for the on-screen overlay.
// Optional session high score built only when SCORE_KEEPER_HISCORE_EN is defined;
// otherwise high_score and new_high are tied to 0.
module score_keeper
    import game_pkg::*;
#(
    parameter int unsigned W           = SCORE_W,
    parameter int unsigned MAX_SCORE   = SCORE_MAX,
    parameter int unsigned OVER_FRAMES = 60
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_tick,
    input  logic         start,
    input  logic         pass_evt,
    input  logic         collide,
    output logic [W-1:0] score,
    output logic [W-1:0] high_score,
    output logic [1:0]   game_state,
    output logic         new_high
);

    localparam int unsigned LOCK_W = (OVER_FRAMES > 0) ? $clog2(OVER_FRAMES + 1) : 1;

    game_state_t       state;
    logic              pass_q;
    logic [LOCK_W-1:0] lock_cnt;
    logic [W-1:0]      run_cnt;
    logic              pass_rise_c;
    logic              cnt_clear_c;
    logic              cnt_inc_c;

    assign pass_rise_c = pass_evt & ~pass_q;
    assign cnt_clear_c = (state == IDLE) && start;
    // A collision in the same cycle as a pass drops the point.
    assign cnt_inc_c   = (state == PLAY) && pass_rise_c && !collide;

    sat_counter #(
        .W   (W),
        .MAX (MAX_SCORE)
    ) u_run_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear_c),
        .inc   (cnt_inc_c),
        .count (run_cnt)
    );

    // Pass-event edge detector, sampled every cycle in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_q <= 1'b0;
        end else begin
            pass_q <= pass_evt;
        end
    end

    // Game FSM with the OVER restart lockout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lock_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= PLAY;
                    end
                end
                PLAY: begin
                    if (collide) begin
                        state    <= OVER;
                        lock_cnt <= LOCK_W'(OVER_FRAMES);
                    end
                end
                OVER: begin
                    if (start && (lock_cnt == '0)) begin
                        state <= IDLE;
                    end
                    if (frame_tick && (lock_cnt != '0)) begin
                        lock_cnt <= lock_cnt - LOCK_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Frame-stable display copy; takes the pre-increment value on a coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            score <= '0;
        end else if (frame_tick) begin
            score <= run_cnt;
        end
    end

    assign game_state = state;

`ifdef SCORE_KEEPER_HISCORE_EN
    // Session best, updated on OVER entry only when strictly beaten.
    always_ff @(posedge clk) begin
        if (rst) begin
            high_score <= '0;
            new_high   <= 1'b0;
        end else if (cnt_clear_c) begin
            new_high <= 1'b0;
        end else if ((state == PLAY) && collide && (run_cnt > high_score)) begin
            high_score <= run_cnt;
            new_high   <= 1'b1;
        end
    end
`else
    assign high_score = '0;
    assign new_high   = 1'b0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: scoring, edge detection, saturation, collision,
// high score, OVER lockout, frame shadowing and mid-game reset.
module tb_score_keeper;

    localparam int unsigned W = 10;

`ifdef SCORE_KEEPER_HISCORE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         frame_tick = 1'b0;
    logic         start = 1'b0;
    logic         pass_evt = 1'b0;
    logic         collide = 1'b0;
    logic [W-1:0] score;
    logic [W-1:0] high_score;
    logic [1:0]   game_state;
    logic         new_high;

    int total = 0;
    int bad   = 0;

    score_keeper #(
        .W           (W),
        .MAX_SCORE   (999),
        .OVER_FRAMES (60)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .start      (start),
        .pass_evt   (pass_evt),
        .collide    (collide),
        .score      (score),
        .high_score (high_score),
        .game_state (game_state),
        .new_high   (new_high)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ftick();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pass_pulses(input int n, input int hi);
        for (int i = 0; i < n; i++) begin
            pass_evt = 1'b1;
            repeat (hi) tick();
            pass_evt = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (game_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", game_state); end
        total++; if (score !== 10'd0) begin bad++; $display("FAIL reset_score got=%0d exp=0", score); end
        total++; if (high_score !== 10'd0) begin bad++; $display("FAIL reset_high got=%0d exp=0", high_score); end
        total++; if (new_high !== 1'b0) begin bad++; $display("FAIL reset_new_high got=%0b exp=0", new_high); end
    endtask

    task automatic test_basic_scoring();
        pulse_start();
        total++; if (game_state !== 2'd1) begin bad++; $display("FAIL start_to_play got=%0d exp=1", game_state); end
        pass_pulses(3, 5);
        total++; if (score !== 10'd0) begin bad++; $display("FAIL score_held_no_tick got=%0d exp=0", score); end
        ftick();
        total++; if (score !== 10'd3) begin bad++; $display("FAIL basic_score got=%0d exp=3", score); end
        total++; if (game_state !== 2'd1) begin bad++; $display("FAIL basic_state got=%0d exp=1", game_state); end
    endtask

    task automatic test_held_pass();
        pass_evt = 1'b1;
        repeat (200) tick();
        pass_evt = 1'b0;
        tick();
        ftick();
        total++; if (score !== 10'd4) begin bad++; $display("FAIL held_pass got=%0d exp=4", score); end
    endtask

    task automatic test_coincident_tick();
        pass_evt   = 1'b1;
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        total++; if (score !== 10'd4) begin bad++; $display("FAIL coincident_pre got=%0d exp=4", score); end
        pass_evt = 1'b0;
        tick();
        ftick();
        total++; if (score !== 10'd5) begin bad++; $display("FAIL coincident_post got=%0d exp=5", score); end
    endtask

    task automatic test_first_collide();
        collide = 1'b1;
        tick();
        collide = 1'b0;
        total++; if (game_state !== 2'd2) begin bad++; $display("FAIL collide1_state got=%0d exp=2", game_state); end
        total++; if (high_score !== (HS ? 10'd5 : 10'd0)) begin bad++; $display("FAIL collide1_high got=%0d exp=%0d", high_score, HS ? 5 : 0); end
        total++; if (new_high !== HS) begin bad++; $display("FAIL collide1_new_high got=%0b exp=%0b", new_high, HS); end
        ftick();
        total++; if (score !== 10'd5) begin bad++; $display("FAIL over_score_kept got=%0d exp=5", score); end
    endtask

    task automatic test_lockout();
        repeat (58) ftick();
        pulse_start();
        total++; if (game_state !== 2'd2) begin bad++; $display("FAIL lockout_59 got=%0d exp=2", game_state); end
        ftick();
        pulse_start();
        total++; if (game_state !== 2'd0) begin bad++; $display("FAIL lockout_60 got=%0d exp=0", game_state); end
        pulse_start();
        total++; if (game_state !== 2'd1) begin bad++; $display("FAIL restart_play got=%0d exp=1", game_state); end
        total++; if (new_high !== 1'b0) begin bad++; $display("FAIL restart_new_high got=%0b exp=0", new_high); end
        total++; if (score !== 10'd5) begin bad++; $display("FAIL restart_score_held got=%0d exp=5", score); end
        ftick();
        total++; if (score !== 10'd0) begin bad++; $display("FAIL restart_score_zero got=%0d exp=0", score); end
    endtask

    task automatic test_collide_with_pass();
        pass_pulses(7, 1);
        pass_evt = 1'b1;
        collide  = 1'b1;
        tick();
        pass_evt = 1'b0;
        collide  = 1'b0;
        total++; if (game_state !== 2'd2) begin bad++; $display("FAIL collide2_state got=%0d exp=2", game_state); end
        ftick();
        total++; if (score !== 10'd7) begin bad++; $display("FAIL collide2_point_dropped got=%0d exp=7", score); end
        total++; if (high_score !== (HS ? 10'd7 : 10'd0)) begin bad++; $display("FAIL collide2_high got=%0d exp=%0d", high_score, HS ? 7 : 0); end
        total++; if (new_high !== HS) begin bad++; $display("FAIL collide2_new_high got=%0b exp=%0b", new_high, HS); end
        repeat (59) ftick();
        pulse_start();
        pulse_start();
    endtask

    task automatic test_equal_high();
        pass_pulses(7, 1);
        collide = 1'b1;
        tick();
        collide = 1'b0;
        total++; if (game_state !== 2'd2) begin bad++; $display("FAIL equal_state got=%0d exp=2", game_state); end
        total++; if (high_score !== (HS ? 10'd7 : 10'd0)) begin bad++; $display("FAIL equal_high got=%0d exp=%0d", high_score, HS ? 7 : 0); end
        total++; if (new_high !== 1'b0) begin bad++; $display("FAIL equal_new_high got=%0b exp=0", new_high); end
        repeat (60) ftick();
        pulse_start();
        pulse_start();
        total++; if (game_state !== 2'd1) begin bad++; $display("FAIL equal_restart got=%0d exp=1", game_state); end
    endtask

    task automatic test_saturation();
        pass_pulses(998, 1);
        ftick();
        total++; if (score !== 10'd998) begin bad++; $display("FAIL sat_998 got=%0d exp=998", score); end
        pass_pulses(3, 1);
        ftick();
        total++; if (score !== 10'd999) begin bad++; $display("FAIL sat_999 got=%0d exp=999", score); end
        collide = 1'b1;
        tick();
        collide = 1'b0;
        total++; if (high_score !== (HS ? 10'd999 : 10'd0)) begin bad++; $display("FAIL sat_high got=%0d exp=%0d", high_score, HS ? 999 : 0); end
    endtask

    task automatic test_midgame_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (game_state !== 2'd0) begin bad++; $display("FAIL rst2_state got=%0d exp=0", game_state); end
        total++; if (score !== 10'd0) begin bad++; $display("FAIL rst2_score got=%0d exp=0", score); end
        total++; if (high_score !== 10'd0) begin bad++; $display("FAIL rst2_high got=%0d exp=0", high_score); end
        total++; if (new_high !== 1'b0) begin bad++; $display("FAIL rst2_new_high got=%0b exp=0", new_high); end
    endtask

    initial begin
        test_reset();
        test_basic_scoring();
        test_held_pass();
        test_coincident_tick();
        test_first_collide();
        test_lockout();
        test_collide_with_pass();
        test_equal_high();
        test_saturation();
        test_midgame_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
